fp_normalizer: RTL and testbench

FP_NORMALIZER -- requirements
Module: fp_normalizer

---
 rtl/fp_normalizer.sv | 156 +++++++++++++++
 tb/tb_fp_normalizer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// Post-add normalizer for IEEE-754 single precision: takes a raw 25-bit mantissa sum
// and the larger operand's exponent, then shifts one bit per cycle until normalized.
module fp_normalizer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sign_in,
    input  logic [7:0]  exp_in,
    input  logic [24:0] mant_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_sign;
    logic [7:0]  r_exp;
    logic [24:0] r_mant;
    logic        r_ovfPend;
    logic        r_unfPend;

    logic [31:0] r_result;
    logic        r_overflow;
    logic        r_underflow;
    logic        r_done;

    logic        w_isZero;
    logic        w_carry;
    logic        w_normed;
    logic        w_needLeft;
    logic        w_underflow;
    logic        w_overflow;
    logic [31:0] w_finalResult;

    // Classification of the working mantissa, evaluated every NORM cycle
    assign w_isZero    = (r_mant == 25'd0);
    assign w_carry     = r_mant[24];
    assign w_normed    = (r_mant[24:23] == 2'b01);
    assign w_needLeft  = !w_isZero && (r_mant[24:23] == 2'b00);
    assign w_underflow = w_needLeft && (r_exp == 8'd1);
    assign w_overflow  = w_carry && (r_exp == 8'd254);

    always_comb begin
        w_finalResult = {r_sign, r_exp, r_mant[22:0]};
        if (r_ovfPend) begin
            w_finalResult = {r_sign, 8'hFF, 23'h0};
        end else if (r_unfPend || w_isZero) begin
            w_finalResult = {r_sign, 8'h00, 23'h0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = NORM;
                end
            end
            NORM: begin
                if (!w_needLeft || w_underflow) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Working registers: captured on an accepted start, then shifted while in NORM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign    <= 1'b0;
            r_exp     <= 8'd0;
            r_mant    <= 25'd0;
            r_ovfPend <= 1'b0;
            r_unfPend <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign    <= sign_in;
                        r_exp     <= exp_in;
                        r_mant    <= mant_in;
                        r_ovfPend <= 1'b0;
                        r_unfPend <= 1'b0;
                    end
                end
                NORM: begin
                    if (w_carry) begin
                        r_mant    <= {1'b0, r_mant[24:1]};
                        r_exp     <= r_exp + 8'd1;
                        r_ovfPend <= w_overflow;
                    end else if (w_underflow) begin
                        r_unfPend <= 1'b1;
                    end else if (w_needLeft) begin
                        r_mant <= {r_mant[23:0], 1'b0};
                        r_exp  <= r_exp - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are registered out of DONE and hold until the next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= 32'd0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE && start) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else if (r_state == DONE) begin
                r_done      <= 1'b1;
                r_result    <= w_finalResult;
                r_overflow  <= r_ovfPend;
                r_underflow <= r_unfPend;
            end
        end
    end

    assign busy      = (r_state == NORM) || (r_state == DONE);
    assign done      = r_done;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed self-checking bench for fp_normalizer: each operation is stepped edge by
// edge from the start-capture edge and checked against hand-computed results.
module tb_fp_normalizer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [24:0] mant_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    int nAsserts = 0;
    int nFails   = 0;

    fp_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a start for one cycle; returns 1ns after the capture edge (edge 0)
    task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [24:0] m);
        sign_in = s;
        exp_in  = e;
        mant_in = m;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_result"}, result, 32'd0);
        checkOutput({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
        checkOutput({tag, "_unf"}, {31'd0, underflow}, 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        sign_in = 1'b0;
        exp_in  = 8'd0;
        mant_in = 25'd0;

        #3;
        checkIdleOutputs("reset");
        #10;
        checkIdleOutputs("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        #2;

        $display("[TB] normalized case");
        applyStimulus(1'b0, 8'h80, 25'h0800000);
        checkOutput("norm_busy_e0", {31'd0, busy}, 32'd1);
        checkOutput("norm_done_e0", {31'd0, done}, 32'd0);
        tick();
        checkOutput("norm_done_e1", {31'd0, done}, 32'd0);
        tick();
        checkOutput("norm_done_e2", {31'd0, done}, 32'd1);
        checkOutput("norm_result", result, 32'h40000000);
        checkOutput("norm_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("norm_unf", {31'd0, underflow}, 32'd0);
        checkOutput("norm_busy_e2", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("norm_done_e3", {31'd0, done}, 32'd0);
        checkOutput("norm_result_hold", result, 32'h40000000);

        $display("[TB] carry case");
        applyStimulus(1'b0, 8'h7F, 25'h1800000);
        tick();
        checkOutput("carry_done_e1", {31'd0, done}, 32'd0);
        tick();
        checkOutput("carry_done_e2", {31'd0, done}, 32'd1);
        checkOutput("carry_result", result, 32'h40400000);
        checkOutput("carry_ovf", {31'd0, overflow}, 32'd0);

        $display("[TB] left-shift case");
        applyStimulus(1'b0, 8'h82, 25'h0200000);
        checkOutput("lshift_busy_e0", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("lshift_busy_e1", {31'd0, busy}, 32'd1);
        checkOutput("lshift_done_e1", {31'd0, done}, 32'd0);
        tick();
        checkOutput("lshift_busy_e2", {31'd0, busy}, 32'd1);
        checkOutput("lshift_done_e2", {31'd0, done}, 32'd0);
        tick();
        checkOutput("lshift_done_e3", {31'd0, done}, 32'd0);
        tick();
        checkOutput("lshift_done_e4", {31'd0, done}, 32'd1);
        checkOutput("lshift_result", result, 32'h40000000);
        checkOutput("lshift_busy_e4", {31'd0, busy}, 32'd0);

        $display("[TB] overflow case");
        applyStimulus(1'b0, 8'hFE, 25'h1000000);
        tick();
        tick();
        checkOutput("ovf_done", {31'd0, done}, 32'd1);
        checkOutput("ovf_result", result, 32'h7F800000);
        checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
        checkOutput("ovf_unf", {31'd0, underflow}, 32'd0);
        tick();
        checkOutput("ovf_flag_hold", {31'd0, overflow}, 32'd1);
        applyStimulus(1'b0, 8'h80, 25'h0800000);
        checkOutput("ovf_clear_on_start", {31'd0, overflow}, 32'd0);
        tick();
        tick();
        checkOutput("after_ovf_result", result, 32'h40000000);

        $display("[TB] underflow case");
        applyStimulus(1'b1, 8'h01, 25'h0400000);
        tick();
        tick();
        checkOutput("unf_done", {31'd0, done}, 32'd1);
        checkOutput("unf_result", result, 32'h80000000);
        checkOutput("unf_flag", {31'd0, underflow}, 32'd1);
        checkOutput("unf_ovf", {31'd0, overflow}, 32'd0);

        $display("[TB] zero case");
        applyStimulus(1'b1, 8'h80, 25'h0000000);
        checkOutput("zero_unf_clear", {31'd0, underflow}, 32'd0);
        tick();
        tick();
        checkOutput("zero_done", {31'd0, done}, 32'd1);
        checkOutput("zero_result", result, 32'h80000000);
        checkOutput("zero_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("zero_unf", {31'd0, underflow}, 32'd0);

        $display("[TB] ignored-start case");
        applyStimulus(1'b0, 8'h82, 25'h0200000);
        tick();
        sign_in = 1'b1;
        exp_in  = 8'h90;
        mant_in = 25'h0800000;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        checkOutput("ign_done_e2", {31'd0, done}, 32'd0);
        tick();
        checkOutput("ign_done_e3", {31'd0, done}, 32'd0);
        tick();
        checkOutput("ign_done_e4", {31'd0, done}, 32'd1);
        checkOutput("ign_result", result, 32'h40000000);
        tick();
        checkOutput("ign_busy_after", {31'd0, busy}, 32'd0);

        $display("[TB] abort case");
        applyStimulus(1'b0, 8'h82, 25'h0200000);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("abort_nodone_%0d", i), {31'd0, done}, 32'd0);
        end
        applyStimulus(1'b0, 8'h82, 25'h0200000);
        tick();
        tick();
        tick();
        tick();
        checkOutput("post_abort_done", {31'd0, done}, 32'd1);
        checkOutput("post_abort_result", result, 32'h40000000);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
